// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART transmit-side control blocks.
package uart_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } sched_state_t;

    // Counter width able to hold the value tmo_cycles itself.
    function automatic int unsigned TMO_W(input int unsigned tmo_cycles);
        return $clog2(tmo_cycles + 1);
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PTR_W'((32'(ptr_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte producers,
// with per-owner packet locking and a frame-completion watchdog.
module uart_tx_sched
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned TMO_CYCLES = 32
) (
    input  logic                     txclk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BYTE_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     err,
    input  logic                     err_clr,
    output logic [15:0]              frame_cnt,
    output logic                     ld_tx_data,
    output logic [BYTE_W-1:0]        tx_data,
    output logic                     tx_enable,
    input  logic                     tx_empty
);

    localparam int unsigned     PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned     CNT_W   = TMO_W(TMO_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYCLES);

    sched_state_t       state_q;
    logic               lock_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [CNT_W-1:0]   wd_q;
    logic [15:0]        frame_cnt_q;

    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    win;
    logic [PTR_W-1:0]   arb_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [BYTE_W-1:0]  win_byte;

    // While locked only the current owner competes, so its index doubles as the pointer.
    assign eligible = lock_q ? (req_valid & grant) : req_valid;
    assign arb_ptr  = lock_q ? owner_q : rr_ptr_q;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i (eligible),
        .ptr_i (arb_ptr),
        .gnt_o (win)
    );

    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx  = PTR_W'(i);
                win_byte = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign tx_enable = en;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge txclk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_q      <= 1'b0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            wd_q        <= '0;
            frame_cnt_q <= '0;
            req_ready   <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            ld_tx_data  <= 1'b0;
            tx_data     <= '0;
        end else begin
            ld_tx_data <= 1'b0;
            req_ready  <= '0;
            if (err_clr) err <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!en) begin
                        lock_q <= 1'b0;
                        grant  <= '0;
                    end else if (tx_empty && |win) begin
                        state_q    <= LOAD;
                        busy       <= 1'b1;
                        grant      <= win;
                        owner_q    <= win_idx;
                        ld_tx_data <= 1'b1;
                        req_ready  <= win;
                        tx_data    <= win_byte;
                    end
                end
                LOAD: begin
                    wd_q <= CNT_W'(1);
                    if (req_last[owner_q]) begin
                        lock_q   <= 1'b0;
                        rr_ptr_q <= (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                    end else begin
                        lock_q <= 1'b1;
                    end
                    if (en) begin
                        state_q <= WAIT_BUSY;
                    end else begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        lock_q  <= 1'b0;
                        grant   <= '0;
                    end
                end
                WAIT_BUSY, WAIT_DONE: begin
                    // Enable drop and watchdog expiry both abandon the frame uncounted.
                    if (!en || wd_q == TMO_LIM) begin
                        if (en) err <= 1'b1;
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        lock_q  <= 1'b0;
                        grant   <= '0;
                    end else if (state_q == WAIT_BUSY && !tx_empty) begin
                        state_q <= WAIT_DONE;
                        wd_q    <= wd_q + 1'b1;
                    end else if (state_q == WAIT_DONE && tx_empty) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= IDLE;
                        busy        <= 1'b0;
                        if (!lock_q) grant <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
